fire_squeeze_seq: RTL and testbench
===================================

Name: fire_squeeze_seq

Overview:
- Sequencer for one squeeze-layer MAC array (DSP_NO parallel MACs sharing one ifm stream).
- Generates ROM tap addresses, the MAC enable and the accumulator clear/commit pulse.
- Serialises the DSP_NO per-pixel results into feature RAM over a valid/ready handshake, and raises the layer-finish flag until downstream acknowledges.
- Replaces per-layer free-running clr counters with one reusable, resettable controller.

Parameters:
- WOUT, 8, output feature-map side; pixels per layer = WOUT**2
- CHIN, 384, input channels
- KERNEL_DIM, 3, kernel side; TAPS = KERNEL_DIM**2*CHIN
- DSP_NO, 112, parallel MACs = output channels per pixel
- MAC_LAT, 2, cycles from last mac_en beat until the accumulator holds its final sum (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  layer start pulse; sampled only in IDLE
- mac_en  out  1  MAC array accumulate enable
- tap_addr  out  $clog2(TAPS)  ifm/kernel ROM address for the current tap
- acc_clr  out  1  commit-and-clear pulse to the MAC array/ofm register
- wr_valid  out  1  write-back word valid
- wr_ready  in  1  feature RAM accepts word
- wr_ch  out  $clog2(DSP_NO)  channel index of the write-back word (ofm mux select)
- wr_pix  out  $clog2(WOUT**2)  pixel index of the write-back word
- busy  out  1  high in every state except IDLE
- finish  out  1  layer complete, held until acknowledged
- ram_feedback  in  1  downstream acknowledge of finish

Behaviour:
- Reset: state=IDLE; all counters 0; mac_en, acc_clr, wr_valid, busy and finish are 0; tap_addr, wr_ch and wr_pix are 0. rst mid-operation aborts immediately to IDLE on the next edge; no partial writes continue.
- All outputs are registered or decoded from state and counters only. No combinational path from wr_ready or ram_feedback to any output.
- IDLE: start=1 moves to ACC with tap=0 and pix=0. start in any other state is ignored.
- ACC: mac_en=1 and tap_addr=tap. tap increments each cycle. When tap==TAPS-1: tap←0, go to FLUSH. Exactly TAPS mac_en cycles per pixel.
- FLUSH: mac_en=0; flush counter f runs 0..MAC_LAT-1. acc_clr=1 only in the cycle f==MAC_LAT-1; the datapath captures ofm and clears its accumulators on that edge. Then go to WRITE with ch=0.
- WRITE: wr_valid=1, wr_ch=ch, wr_pix=pix. On wr_valid&&wr_ready, ch increments. wr_valid stays high and wr_ch stays stable while wr_ready=0.
  - Last channel (ch==DSP_NO-1) accepted and pix==WOUT**2-1: go to DONE.
  - Last channel accepted otherwise: pix++, ch←0, go to ACC.
- DONE: finish=1 and busy=1.
  - ram_feedback=1: go to IDLE; finish is 0 on the following cycle.
  - ram_feedback already high on entry to DONE: finish is high exactly one cycle.
- Minimum cycles per pixel = TAPS + MAC_LAT + DSP_NO. Layer total = WOUT**2 × that, plus stall cycles.
- Counter widths are sized so TAPS-1, DSP_NO-1 and WOUT**2-1 fit exactly. No counter wraps except under the explicit terminal-count compares above.
- Simultaneous rst and start: rst wins.

Decomposition:
- Shared package fire_pkg holds:
  - state enum (IDLE, ACC, FLUSH, WRITE, DONE)
  - localparam functions for TAPS and counter widths
- Natural sub-module: term_counter (parameterised max, inc, clear, terminal-count flag), used for tap, flush, ch and pix.

Test Plan:
1. Params KERNEL_DIM=1, CHIN=4, WOUT=2, DSP_NO=3, MAC_LAT=2, wr_ready tied 1; start pulse.
   - Per pixel: mac_en high 4 cycles with tap_addr 0,1,2,3; acc_clr exactly 2 cycles after the last mac_en beat; wr_ch 0,1,2.
   - finish rises 4×(4+2+3)=36 cycles after the ACC entry edge.
2. Same params, wr_ready low for 5 cycles while wr_ch=1 of pixel 0.
   - wr_valid and wr_ch=1 held stable all 5 cycles; no mac_en during the stall.
   - finish is delayed by exactly 5 cycles versus scenario 1.
3. rst asserted for 1 cycle during ACC tap 2 of pixel 1 → next cycle IDLE, all outputs 0. A new start then re-runs from pix=0, tap=0 with the scenario-1 timing.
4. ram_feedback held 0 for 10 cycles in DONE → finish high all 10 cycles. ram_feedback=1 → finish 0 the next cycle, busy 0, state IDLE.
5. start pulses during ACC/WRITE and start coincident with rst → ignored: no counter disturbance, identical trace to scenario 1.
6. Default params, wr_ready=1 → per pixel exactly 3456 mac_en cycles, one acc_clr and 112 write beats. 64 pixels; finish rises at cycle 64×3570.

Source files
------------

// File: rtl/fire_squeeze_seq_pkg.sv
// Shared types and sizing helpers for the squeeze-layer sequencer.
//   state_t : sequencer states
//   taps_of : MAC beats per output pixel (kernel area x input channels)
//   cnt_w   : counter width holding 0..n-1 (minimum one bit)
package fire_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACC   = 3'd1,
        FLUSH = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic int unsigned taps_of(input int unsigned kernel_dim,
                                            input int unsigned chin);
        return kernel_dim * kernel_dim * chin;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fire_squeeze_seq_if.sv
// Write-back channel from the sequencer into feature RAM.
//   wr_valid : word valid (master)
//   wr_ready : RAM accepts word (slave)
//   wr_ch    : output channel of the word / ofm mux select (master)
//   wr_pix   : pixel index of the word (master)
interface fire_squeeze_seq_if #(
    parameter int unsigned CH_W  = 7,
    parameter int unsigned PIX_W = 6
);
    logic             wr_valid;
    logic             wr_ready;
    logic [CH_W-1:0]  wr_ch;
    logic [PIX_W-1:0] wr_pix;

    modport master (output wr_valid, output wr_ch, output wr_pix, input wr_ready);
    modport slave  (input wr_valid, input wr_ch, input wr_pix, output wr_ready);
endinterface

// File: rtl/fire_squeeze_seq_term_counter.sv
// Up-counter 0..MAX that wraps to 0 only when incremented at its terminal count.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (priority over inc)
//   inc      : count enable
//   cnt      : current count
//   tc       : cnt == MAX
module term_counter #(
    parameter int unsigned MAX = 1,
    parameter int unsigned W   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         tc
);

    assign tc = (cnt == W'(MAX));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= tc ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/fire_squeeze_seq.sv
// Sequencer for one squeeze-layer MAC array: walks TAPS accumulate beats per
// pixel, waits MAC_LAT cycles and pulses acc_clr, then writes DSP_NO channel
// words back over the wr handshake; after the last pixel holds finish until
// ram_feedback.
//   clk, rst     : clock, synchronous active-high reset
//   start        : layer start (only honoured in IDLE)
//   mac_en       : accumulate enable
//   tap_addr     : ROM address of the current tap
//   acc_clr      : commit-and-clear pulse to the MAC array
//   wr           : write-back channel (valid/ready, channel, pixel)
//   busy         : high in every state except IDLE
//   finish       : layer complete, held until ram_feedback
//   ram_feedback : downstream acknowledge of finish
module fire_squeeze_seq
    import fire_pkg::*;
#(
    parameter int unsigned WOUT       = 8,
    parameter int unsigned CHIN       = 384,
    parameter int unsigned KERNEL_DIM = 3,
    parameter int unsigned DSP_NO     = 112,
    parameter int unsigned MAC_LAT    = 2
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    output logic                                      mac_en,
    output logic [cnt_w(taps_of(KERNEL_DIM, CHIN))-1:0] tap_addr,
    output logic                                      acc_clr,
    fire_squeeze_seq_if.master                        wr,
    output logic                                      busy,
    output logic                                      finish,
    input  logic                                      ram_feedback
);

    localparam int unsigned TAPS   = taps_of(KERNEL_DIM, CHIN);
    localparam int unsigned PIXELS = WOUT * WOUT;
    localparam int unsigned TAP_W  = cnt_w(TAPS);
    localparam int unsigned FL_W   = cnt_w(MAC_LAT);
    localparam int unsigned CH_W   = cnt_w(DSP_NO);
    localparam int unsigned PIX_W  = cnt_w(PIXELS);

    state_t state_q, state_d;

    logic [TAP_W-1:0] tap_cnt;
    logic [FL_W-1:0]  fl_cnt;
    logic [CH_W-1:0]  ch_cnt;
    logic [PIX_W-1:0] pix_cnt;
    logic tap_tc, fl_tc, ch_tc, pix_tc;
    logic tap_inc, fl_inc, ch_inc, pix_inc, pix_clr;

    term_counter #(.MAX(TAPS - 1), .W(TAP_W)) u_tap (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(tap_inc), .cnt(tap_cnt), .tc(tap_tc)
    );
    term_counter #(.MAX(MAC_LAT - 1), .W(FL_W)) u_flush (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(fl_inc), .cnt(fl_cnt), .tc(fl_tc)
    );
    term_counter #(.MAX(DSP_NO - 1), .W(CH_W)) u_ch (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(ch_inc), .cnt(ch_cnt), .tc(ch_tc)
    );
    term_counter #(.MAX(PIXELS - 1), .W(PIX_W)) u_pix (
        .clk(clk), .rst(rst), .clr(pix_clr), .inc(pix_inc), .cnt(pix_cnt), .tc(pix_tc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and counter controls; tap/flush/ch self-wrap at terminal count
    always_comb begin
        state_d = state_q;
        tap_inc = 1'b0;
        fl_inc  = 1'b0;
        ch_inc  = 1'b0;
        pix_inc = 1'b0;
        pix_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                pix_clr = 1'b1;
                if (start) state_d = ACC;
            end
            ACC: begin
                tap_inc = 1'b1;
                if (tap_tc) state_d = FLUSH;
            end
            FLUSH: begin
                fl_inc = 1'b1;
                if (fl_tc) state_d = WRITE;
            end
            WRITE: begin
                if (wr.wr_ready) begin
                    ch_inc = 1'b1;
                    if (ch_tc) begin
                        if (pix_tc) begin
                            state_d = DONE;
                        end else begin
                            pix_inc = 1'b1;
                            state_d = ACC;
                        end
                    end
                end
            end
            DONE: begin
                // Clear pix on exit so IDLE shows wr_pix = 0 immediately
                if (ram_feedback) begin
                    pix_clr = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode only the state register and counters
    assign mac_en      = (state_q == ACC);
    assign tap_addr    = tap_cnt;
    assign acc_clr     = (state_q == FLUSH) && (fl_cnt == FL_W'(MAC_LAT - 1));
    assign wr.wr_valid = (state_q == WRITE);
    assign wr.wr_ch    = ch_cnt;
    assign wr.wr_pix   = pix_cnt;
    assign busy        = (state_q != IDLE);
    assign finish      = (state_q == DONE);

endmodule

// File: tb/tb_fire_squeeze_seq.sv
// Randomised scoreboard bench for fire_squeeze_seq with a small layer
// (1x1 kernel, 4 input channels, 2x2 output, 3 MACs, MAC_LAT 2).
module tb_fire_squeeze_seq;

    localparam int unsigned WOUT    = 2;
    localparam int unsigned CHIN    = 4;
    localparam int unsigned KD      = 1;
    localparam int unsigned DSP     = 3;
    localparam int unsigned ML      = 2;
    localparam int unsigned TAPS    = KD * KD * CHIN;
    localparam int unsigned PIXELS  = WOUT * WOUT;
    localparam int unsigned TAP_W   = $clog2(TAPS);
    localparam int unsigned CH_W    = $clog2(DSP);
    localparam int unsigned PIX_W   = $clog2(PIXELS);
    localparam int          RUN_LEN = 512;

    logic clk = 1'b0;
    logic rst, start, ram_feedback;
    logic mac_en, acc_clr, busy, finish;
    logic [TAP_W-1:0] tap_addr;

    fire_squeeze_seq_if #(.CH_W(CH_W), .PIX_W(PIX_W)) wr_if ();

    fire_squeeze_seq #(
        .WOUT(WOUT), .CHIN(CHIN), .KERNEL_DIM(KD), .DSP_NO(DSP), .MAC_LAT(ML)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mac_en(mac_en), .tap_addr(tap_addr),
        .acc_clr(acc_clr), .wr(wr_if), .busy(busy), .finish(finish),
        .ram_feedback(ram_feedback)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned t;
        int unsigned a;
        int unsigned b;
    } ev_t;

    ev_t mac_q[$];
    ev_t clr_q[$];
    ev_t wr_q[$];
    ev_t fin_q[$];

    bit          rdy_pat[RUN_LEN];
    int unsigned base;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle_check(input string tag);
        check({tag, " mac_en"}, 32'(mac_en), 0);
        check({tag, " acc_clr"}, 32'(acc_clr), 0);
        check({tag, " wr_valid"}, 32'(wr_if.wr_valid), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " finish"}, 32'(finish), 0);
        check({tag, " tap_addr"}, 32'(tap_addr), 0);
        check({tag, " wr_ch"}, 32'(wr_if.wr_ch), 0);
        check({tag, " wr_pix"}, 32'(wr_if.wr_pix), 0);
    endtask

    // Timeline model: start sampled at the end of relative interval 0, so the
    // layer's first ACC interval is 1. Each pixel: TAPS mac beats, MAC_LAT flush
    // intervals with acc_clr in the last, then one accept per channel on the
    // first interval where wr_ready is high. Events after an abort are dropped.
    task automatic model(input int abort_rel, input int fb_delay,
                         output int done_rel, output int end_rel);
        int t;
        ev_t e;
        t = 1;
        for (int p = 0; p < int'(PIXELS); p++) begin
            for (int k = 0; k < int'(TAPS); k++) begin
                e = '{base + t, k, 0};
                if (abort_rel == 0 || t <= abort_rel) mac_q.push_back(e);
                t++;
            end
            t += ML - 1;
            e = '{base + t, 0, 0};
            if (abort_rel == 0 || t <= abort_rel) clr_q.push_back(e);
            t++;
            for (int c = 0; c < int'(DSP); c++) begin
                while (t < RUN_LEN && !rdy_pat[t]) t++;
                e = '{base + t, p, c};
                if (abort_rel == 0 || t <= abort_rel) wr_q.push_back(e);
                t++;
            end
        end
        done_rel = t;
        for (int k = 0; k <= fb_delay; k++) begin
            e = '{base + t + k, 0, 0};
            if (abort_rel == 0 || t + k <= abort_rel) fin_q.push_back(e);
        end
        end_rel = (abort_rel != 0) ? abort_rel + 1 : t + fb_delay + 1;
    endtask

    // Monitor: pops an expected event whenever the DUT presents one
    always @(negedge clk) begin
        ev_t e;
        if (mac_en === 1'b1) begin
            if (mac_q.size() == 0) check("mac_en spurious", 32'(mac_en), 0);
            else begin
                e = mac_q.pop_front();
                check("mac_en cycle", cyc, e.t);
                check("tap_addr", 32'(tap_addr), e.a);
            end
        end
        if (acc_clr === 1'b1) begin
            if (clr_q.size() == 0) check("acc_clr spurious", 32'(acc_clr), 0);
            else begin
                e = clr_q.pop_front();
                check("acc_clr cycle", cyc, e.t);
            end
        end
        if (wr_if.wr_valid === 1'b1) begin
            if (wr_q.size() == 0) check("wr_valid spurious", 32'(wr_if.wr_valid), 0);
            else begin
                e = wr_q[0];
                check("wr_pix", 32'(wr_if.wr_pix), e.a);
                check("wr_ch", 32'(wr_if.wr_ch), e.b);
                if (wr_if.wr_ready === 1'b1) begin
                    check("wr accept cycle", cyc, e.t);
                    void'(wr_q.pop_front());
                end
            end
        end
        if (finish === 1'b1) begin
            if (fin_q.size() == 0) check("finish spurious", 32'(finish), 0);
            else begin
                e = fin_q.pop_front();
                check("finish cycle", cyc, e.t);
                check("busy in done", 32'(busy), 1);
            end
        end
    end

    // stall_mode: 0 ready always, 1 ready low for 5 cycles at pixel 0 ch 1,
    // 2 random. abort_rel != 0 pulses rst in that interval.
    task automatic run_layer(input int stall_mode, input int fb_delay, input int abort_rel,
                             input bit spur, input bit rst_start);
        int done_rel, end_rel;
        @(posedge clk);
        #1;
        base = cyc;
        for (int i = 0; i < RUN_LEN; i++) begin
            case (stall_mode)
                0:       rdy_pat[i] = 1'b1;
                1:       rdy_pat[i] = !(i >= 8 && i <= 12);
                default: rdy_pat[i] = ($urandom_range(0, 99) >= 35);
            endcase
        end
        model(abort_rel, fb_delay, done_rel, end_rel);
        for (int i = 0; i <= end_rel + 1; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (i == end_rel) idle_check("idle");
            rst   = (abort_rel != 0) && (i == abort_rel);
            start = (i == 0) || (rst && rst_start) ||
                    (spur && i > 0 && i < end_rel && $urandom_range(0, 3) == 0);
            wr_if.wr_ready = (i < RUN_LEN) ? rdy_pat[i] : 1'b1;
            if (abort_rel == 0 && i >= done_rel)
                ram_feedback = (i >= done_rel + fb_delay);
            else
                ram_feedback = ($urandom_range(0, 1) == 1);
        end
        start = 1'b0;
        rst   = 1'b0;
        check("mac events drained", mac_q.size(), 0);
        check("acc_clr events drained", clr_q.size(), 0);
        check("write events drained", wr_q.size(), 0);
        check("finish events drained", fin_q.size(), 0);
        mac_q.delete();
        clr_q.delete();
        wr_q.delete();
        fin_q.delete();
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b1;
        ram_feedback   = 1'b0;
        wr_if.wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        idle_check("reset");
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        idle_check("post-reset");

        run_layer(0, 0, 0, 1'b0, 1'b0);   // nominal, ack already high at DONE
        run_layer(1, 3, 0, 1'b0, 1'b0);   // 5-cycle stall at pixel 0 channel 1
        run_layer(0, 0, 12, 1'b0, 1'b0);  // rst at pixel 1 tap 2
        run_layer(0, 0, 0, 1'b0, 1'b0);   // clean restart after abort
        run_layer(0, 10, 0, 1'b0, 1'b0);  // finish held 10 extra cycles
        run_layer(0, 2, 0, 1'b1, 1'b0);   // spurious start pulses while busy
        run_layer(0, 0, 20, 1'b1, 1'b1);  // start coincident with rst
        run_layer(0, 0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            run_layer(2, int'($urandom_range(0, 4)), 0, 1'b1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
